// File: rtl/fpu_mult_ctrl_fsm_pkg.sv
// fpu_mult_ctrl_fsm_pkg: state codes, defaults and output decode for the FP multiplier sequencer
package fpu_mult_ctrl_fsm_pkg;
   localparam int MULT_LAT_DEF = 2;
   localparam int W_SGF_SP     = 23;
   localparam int W_SGF_DP     = 52;

   localparam logic [3:0] ST_IDLE      = 4'd0;
   localparam logic [3:0] ST_LOAD_OP   = 4'd1;
   localparam logic [3:0] ST_EXP_ADD   = 4'd2;
   localparam logic [3:0] ST_EXP_CHK   = 4'd3;
   localparam logic [3:0] ST_SGF_MULT  = 4'd4;
   localparam logic [3:0] ST_NORM      = 4'd5;
   localparam logic [3:0] ST_NORM_CHK  = 4'd6;
   localparam logic [3:0] ST_EXP_NORM  = 4'd7;
   localparam logic [3:0] ST_ROUND_CHK = 4'd8;
   localparam logic [3:0] ST_ROUND_LD  = 4'd9;
   localparam logic [3:0] ST_RND_CHK   = 4'd10;
   localparam logic [3:0] ST_EXP_RND   = 4'd11;
   localparam logic [3:0] ST_FINAL     = 4'd12;
   localparam logic [3:0] ST_READY     = 4'd13;

   typedef struct packed {
      logic busy;
      logic ready;
      logic load_final;
      logic load_exp_upd;
      logic sel_norm;
      logic load_norm;
      logic load_sgf;
      logic load_exp;
      logic load_op;
   } ctrl_t;

   // first marks the opening cycle of SGF_MULT so the multiply start fires once per entry
   function automatic ctrl_t decode(logic [3:0] s, logic first);
      ctrl_t c;
      c.busy         = (s != ST_IDLE) && (s <= ST_READY);
      c.ready        = s == ST_READY;
      c.load_final   = s == ST_FINAL;
      c.load_exp_upd = (s == ST_EXP_NORM) || (s == ST_EXP_RND);
      c.sel_norm     = (s == ST_ROUND_LD) || (s == ST_RND_CHK) || (s == ST_EXP_RND);
      c.load_norm    = (s == ST_NORM) || (s == ST_ROUND_LD);
      c.load_sgf     = (s == ST_SGF_MULT) && first;
      c.load_exp     = s == ST_EXP_ADD;
      c.load_op      = s == ST_LOAD_OP;
      return c;
   endfunction
endpackage

// File: rtl/fpu_mult_ctrl_fsm_if.sv
// fpu_mult_ctrl_fsm_if: handshake, datapath status and strobe bundle between FPU top/datapath and the sequencer
interface fpu_mult_ctrl_fsm_if;
   logic beg_FSM;
   logic ack_FSM;
   logic zero_flag_i;
   logic exp_ovf_i;
   logic exp_nu_i;
   logic round_need_i;
   logic load_op_o;
   logic load_exp_o;
   logic load_sgf_o;
   logic load_norm_o;
   logic sel_norm_o;
   logic load_exp_upd_o;
   logic load_final_o;
   logic ready_o;
   logic busy_o;

   modport master (
      output beg_FSM, ack_FSM, zero_flag_i, exp_ovf_i, exp_nu_i, round_need_i,
      input  load_op_o, load_exp_o, load_sgf_o, load_norm_o, sel_norm_o,
             load_exp_upd_o, load_final_o, ready_o, busy_o
   );

   modport slave (
      input  beg_FSM, ack_FSM, zero_flag_i, exp_ovf_i, exp_nu_i, round_need_i,
      output load_op_o, load_exp_o, load_sgf_o, load_norm_o, sel_norm_o,
             load_exp_upd_o, load_final_o, ready_o, busy_o
   );
endinterface

// File: rtl/fpu_mult_ctrl_fsm_mult_lat_counter.sv
// fpu_mult_ctrl_fsm_mult_lat_counter: 4-bit wait counter for the significand multiplier latency
module fpu_mult_ctrl_fsm_mult_lat_counter #(
   parameter int MULT_LAT = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic first,
   output logic tc
);
   logic [3:0] cnt;

   // held at zero outside the multiply wait so every entry starts counting from 0
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en) cnt <= cnt + 4'd1;
   end

   assign first = cnt == 4'd0;
   assign tc    = cnt == 4'(MULT_LAT - 1);
endmodule

// File: rtl/fpu_mult_ctrl_fsm.sv
// fpu_mult_ctrl_fsm: sequencing FSM driving the FP multiplier datapath load/select lines
module fpu_mult_ctrl_fsm
   import fpu_mult_ctrl_fsm_pkg::*;
#(
   parameter int W_Sgf    = W_SGF_SP,
   parameter int MULT_LAT = MULT_LAT_DEF
) (
   input logic                clk,
   input logic                rst,
   fpu_mult_ctrl_fsm_if.slave bus
);
   logic [3:0] state, state_nx;
   logic       lat_first, lat_tc;
   ctrl_t      c;

   if (MULT_LAT < 1 || MULT_LAT > 15 || W_Sgf < 1) begin : g_bad_param
      $error("fpu_mult_ctrl_fsm: MULT_LAT must be 1..15 and W_Sgf positive");
   end

   fpu_mult_ctrl_fsm_mult_lat_counter #(.MULT_LAT(MULT_LAT)) u_lat (
      .clk   (clk),
      .rst   (rst),
      .clr   (state != ST_SGF_MULT),
      .en    (1'b1),
      .first (lat_first),
      .tc    (lat_tc)
   );

   // state register; reset aborts any operation immediately
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else state <= state_nx;
   end

   // next-state selection; datapath flags are only looked at in the state that owns them
   always_comb begin
      state_nx = ST_IDLE;
      case (state)
         ST_IDLE:      state_nx = bus.beg_FSM ? ST_LOAD_OP : ST_IDLE;
         ST_LOAD_OP:   state_nx = ST_EXP_ADD;
         ST_EXP_ADD:   state_nx = bus.zero_flag_i ? ST_FINAL : ST_EXP_CHK;
         ST_EXP_CHK:   state_nx = bus.exp_ovf_i ? ST_FINAL : ST_SGF_MULT;
         ST_SGF_MULT:  state_nx = lat_tc ? ST_NORM : ST_SGF_MULT;
         ST_NORM:      state_nx = ST_NORM_CHK;
         ST_NORM_CHK:  state_nx = bus.exp_nu_i ? ST_EXP_NORM : ST_ROUND_CHK;
         ST_EXP_NORM:  state_nx = ST_ROUND_CHK;
         ST_ROUND_CHK: state_nx = bus.round_need_i ? ST_ROUND_LD : ST_FINAL;
         ST_ROUND_LD:  state_nx = ST_RND_CHK;
         ST_RND_CHK:   state_nx = bus.exp_nu_i ? ST_EXP_RND : ST_FINAL;
         ST_EXP_RND:   state_nx = ST_FINAL;
         ST_FINAL:     state_nx = ST_READY;
         ST_READY:     state_nx = bus.ack_FSM ? ST_IDLE : ST_READY;
         default:      state_nx = ST_IDLE;
      endcase
   end

   assign c = decode(state, lat_first);

   assign bus.load_op_o      = c.load_op;
   assign bus.load_exp_o     = c.load_exp;
   assign bus.load_sgf_o     = c.load_sgf;
   assign bus.load_norm_o    = c.load_norm;
   assign bus.sel_norm_o     = c.sel_norm;
   assign bus.load_exp_upd_o = c.load_exp_upd;
   assign bus.load_final_o   = c.load_final;
   assign bus.ready_o        = c.ready;
   assign bus.busy_o         = c.busy;
endmodule

// File: tb/tb_fpu_mult_ctrl_fsm.sv
// tb_fpu_mult_ctrl_fsm: randomized sequencing check of fpu_mult_ctrl_fsm against an expected strobe schedule
module tb_fpu_mult_ctrl_fsm;
   localparam int ML = 2;
   localparam logic [8:0] B_OP = 9'h001, B_EXP = 9'h002, B_SGF = 9'h004, B_NORM = 9'h008, B_SEL = 9'h010;
   localparam logic [8:0] B_UPD = 9'h020, B_FIN = 9'h040, B_RDY = 9'h080, B_BUSY = 9'h100;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   logic [8:0] exp_q[$];
   bit         nu_q[$];

   fpu_mult_ctrl_fsm_if bus();

   fpu_mult_ctrl_fsm #(.W_Sgf(23), .MULT_LAT(ML)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   function automatic logic [8:0] outs();
      return {bus.busy_o, bus.ready_o, bus.load_final_o, bus.load_exp_upd_o, bus.sel_norm_o,
              bus.load_norm_o, bus.load_sgf_o, bus.load_exp_o, bus.load_op_o};
   endfunction

   task automatic check(input string tag, input logic [8:0] got, input logic [8:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %b expected %b (busy,rdy,fin,upd,sel,norm,sgf,exp,op)", tag, got, want);
      end
   endtask

   task automatic push(input logic [8:0] v, input bit nu);
      exp_q.push_back(v);
      nu_q.push_back(nu);
   endtask

   // expected per-cycle outputs from LOAD_OP up to FINAL; exp_nu is random wherever it is not consulted
   task automatic build(input bit zero, input bit ovf, input bit nu1, input bit rnd, input bit nu2);
      exp_q = {};
      nu_q  = {};
      push(B_BUSY | B_OP, 1'($urandom));
      push(B_BUSY | B_EXP, 1'($urandom));
      if (!zero) begin
         push(B_BUSY, 1'($urandom));
         if (!ovf) begin
            push(B_BUSY | B_SGF, 1'($urandom));
            for (int i = 1; i < ML; i++) push(B_BUSY, 1'($urandom));
            push(B_BUSY | B_NORM, 1'($urandom));
            push(B_BUSY, nu1);
            if (nu1) push(B_BUSY | B_UPD, 1'($urandom));
            push(B_BUSY, 1'($urandom));
            if (rnd) begin
               push(B_BUSY | B_NORM | B_SEL, 1'($urandom));
               push(B_BUSY | B_SEL, nu2);
               if (nu2) push(B_BUSY | B_SEL | B_UPD, 1'($urandom));
            end
         end
      end
      push(B_BUSY | B_FIN, 1'($urandom));
   endtask

   // called at a negedge while idle; leaves the DUT idle at a negedge
   task automatic run_op(input string tag, input bit zero, input bit ovf, input bit nu1, input bit rnd,
                         input bit nu2, input bit hold, input int nw, input int rst_at);
      build(zero, ovf, nu1, rnd, nu2);
      bus.zero_flag_i  = zero;
      bus.exp_ovf_i    = ovf;
      bus.round_need_i = rnd;
      bus.beg_FSM      = 1'b1;
      foreach (exp_q[i]) begin
         @(negedge clk);
         bus.beg_FSM  = hold;
         bus.ack_FSM  = 1'($urandom);
         bus.exp_nu_i = nu_q[i];
         check({tag, "_step"}, outs(), exp_q[i]);
         if (i == rst_at) begin
            #1 rst = 1'b1;
            #1 check({tag, "_async_rst"}, outs(), 9'h000);
            @(negedge clk);
            check({tag, "_in_rst"}, outs(), 9'h000);
            rst          = 1'b0;
            bus.beg_FSM  = 1'b0;
            bus.ack_FSM  = 1'b0;
            return;
         end
      end
      for (int w = 0; w <= nw; w++) begin
         @(negedge clk);
         bus.ack_FSM = (w == nw);
         check({tag, "_ready"}, outs(), B_BUSY | B_RDY);
      end
      @(negedge clk);
      check({tag, "_idle"}, outs(), 9'h000);
      bus.ack_FSM = 1'b0;
      bus.beg_FSM = 1'b0;
   endtask

   initial begin
      rst              = 1'b1;
      bus.beg_FSM      = 1'b0;
      bus.ack_FSM      = 1'b0;
      bus.zero_flag_i  = 1'b0;
      bus.exp_ovf_i    = 1'b0;
      bus.exp_nu_i     = 1'b0;
      bus.round_need_i = 1'b0;
      repeat (2) @(negedge clk);
      check("reset", outs(), 9'h000);
      rst = 1'b0;
      bus.ack_FSM = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("idle_ack_ignored", outs(), 9'h000);
      end
      bus.ack_FSM = 1'b0;
      run_op("plain",     0, 0, 0, 0, 0, 0, 0, -1);
      run_op("full",      0, 0, 1, 1, 1, 0, 0, -1);
      run_op("zero",      1, 0, 1, 1, 1, 0, 1, -1);
      run_op("ovf",       0, 1, 1, 1, 1, 0, 5, -1);
      run_op("rst",       0, 0, 0, 0, 0, 0, 0, 4);
      run_op("after_rst", 0, 0, 1, 0, 0, 0, 0, -1);
      run_op("hold",      0, 0, 0, 1, 1, 1, 2, -1);
      for (int n = 0; n < 60; n++) begin
         run_op("rand", $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, 1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), $urandom_range(0, 4),
                ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 6)) : -1);
         if ($urandom_range(0, 1) == 1) begin
            @(negedge clk);
            check("rand_idle_gap", outs(), 9'h000);
         end
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
